// File: rtl/obc_da_mac.sv
// Bit-serial offset-binary-coded distributed-arithmetic MAC: y = +/- sum(c_i * x_i),
// one bit-slice of all N samples per clock, MSB first, with a run-time coefficient bank.
module obc_da_mac #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int CW = 16,
    parameter int AW = CW + W + $clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic [CW-1:0]        coef_wdata,
    output logic                 coef_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       x_in,
    input  logic                 neg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        y_out
);
    localparam int NP  = N / 2;
    localparam int ADW = $clog2(N);
    localparam int BW  = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [CW-1:0] coef_q [N];
    logic signed [CW-1:0] coef_d [N];
    logic signed [AW-1:0] psum_q [NP];
    logic signed [AW-1:0] psum_d [NP];
    logic signed [AW-1:0] pdif_q [NP];
    logic signed [AW-1:0] pdif_d [NP];
    logic signed [AW-1:0] csum_q, csum_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] y_q, y_d;
    logic signed [AW-1:0] slice_s, fix_diff, fix_t;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 coef_err_q, coef_err_d;
    logic [N*W-1:0]       x_q;
    logic                 neg_q;
    logic [W-1:0]         samp [N];
    logic                 accept, coef_ok;

    function automatic logic signed [AW-1:0] sext(input logic signed [CW-1:0] v);
        return {{(AW-CW){v[CW-1]}}, v};
    endfunction

    // OBC pair term: +/-(c0+c1) when the two bits agree, +/-(c0-c1) otherwise; sign from b0.
    function automatic logic signed [AW-1:0] pair_term(input logic signed [AW-1:0] ps,
                                                       input logic signed [AW-1:0] pd,
                                                       input logic b0, input logic b1);
        logic signed [AW-1:0] t;
        t = (b0 == b1) ? ps : pd;
        return b0 ? t : -t;
    endfunction

    assign accept    = in_valid && (state_q == IDLE);
    assign coef_ok   = coef_we && (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign coef_err  = coef_err_q;
    assign y_out     = y_q;

    always_comb begin
        csum_d = '0;
        for (int i = 0; i < N; i++) begin
            coef_d[i] = coef_q[i];
            if (coef_ok && (coef_addr == ADW'(i))) coef_d[i] = coef_wdata;
        end
        for (int k = 0; k < NP; k++) begin
            psum_d[k] = sext(coef_d[2*k]) + sext(coef_d[2*k+1]);
            pdif_d[k] = sext(coef_d[2*k]) - sext(coef_d[2*k+1]);
            csum_d    = csum_d + psum_d[k];
        end
    end

    always_comb begin
        slice_s = '0;
        for (int i = 0; i < N; i++) samp[i] = x_q[i*W +: W];
        for (int k = 0; k < NP; k++)
            slice_s = slice_s + pair_term(psum_q[k], pdif_q[k],
                                          samp[2*k][bit_q], samp[2*k+1][bit_q]);
        fix_diff = acc_q - csum_q;
        fix_t    = fix_diff >>> 1;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        y_d        = y_q;
        coef_err_d = coef_we && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    bit_d   = BW'(W - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // The MSB slice carries negative weight in two's complement.
                if (bit_q == BW'(W - 1)) acc_d = (acc_q <<< 1) - slice_s;
                else                     acc_d = (acc_q <<< 1) + slice_s;
                if (bit_q == '0) state_d = FIX;
                else             bit_d   = bit_q - BW'(1);
            end
            FIX: begin
                y_d     = neg_q ? -fix_t : fix_t;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            bit_q      <= '0;
            y_q        <= '0;
            coef_err_q <= 1'b0;
            csum_q     <= '0;
            for (int i = 0; i < N; i++) coef_q[i] <= '0;
            for (int k = 0; k < NP; k++) begin
                psum_q[k] <= '0;
                pdif_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            bit_q      <= bit_d;
            y_q        <= y_d;
            coef_err_q <= coef_err_d;
            csum_q     <= csum_d;
            for (int i = 0; i < N; i++) coef_q[i] <= coef_d[i];
            for (int k = 0; k < NP; k++) begin
                psum_q[k] <= psum_d[k];
                pdif_q[k] <= pdif_d[k];
            end
        end
    end

    // Sample data needs no reset: it is only read after an accepting edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q   <= x_in;
            neg_q <= neg;
        end
    end
endmodule

// File: tb/tb_obc_da_mac.sv
// Directed self-checking bench for obc_da_mac with hand-computed expected results.
module tb_obc_da_mac;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int CW = 16;
    localparam int AW = 37;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coef_we = 1'b0;
    logic [3:0]    coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          coef_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*W-1:0] x_in = '0;
    logic          neg = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] y_out;

    int n_chk  = 0;
    int n_fail = 0;

    obc_da_mac #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .neg(neg),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ysig();
        logic signed [AW-1:0] s;
        s = y_out;
        return longint'(s);
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = v;
        return f;
    endfunction

    task automatic load_coef(input int a, input int v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 4'(a);
        coef_wdata = 16'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic load_all(input int v);
        for (int i = 0; i < N; i++) load_coef(i, v);
    endtask

    // Present one vector; return once out_valid is seen (or the budget expires).
    task automatic send(input logic [N*W-1:0] xv, input logic ng, output int lat);
        int wait_c;
        wait_c = 0;
        @(negedge clk);
        while (!in_ready && wait_c < 100) begin @(negedge clk); wait_c++; end
        x_in = xv; neg = ng; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [N*W-1:0] xv, input logic ng,
                       input longint exp);
        int lat;
        send(xv, ng, lat);
        check_eq({tag, "_lat"}, lat, W + 1);
        check_eq({tag, "_y"}, ysig(), exp);
        consume();
    endtask

    initial begin
        logic [N*W-1:0] xv;
        longint held;
        int lat;

        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_coef_err", coef_err, 0);
        check_eq("rst_y", ysig(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        load_all(1);
        vec("ones", fill(16'd1), 1'b0, 16);

        load_all(32767);
        vec("maxc_minx", fill(16'h8000), 1'b0, -64'sd17179344896);
        load_all(-32768);
        vec("minc_minx", fill(16'h8000), 1'b0, 64'sd17179869184);
        vec("minc_maxx", fill(16'h7fff), 1'b0, -64'sd17179344896);

        load_all(0);
        load_coef(0, 3);
        load_coef(1, -7);
        xv = '0; xv[0 +: W] = 16'd100; xv[W +: W] = -16'sd20;
        vec("pair_mix", xv, 1'b0, 440);

        xv = '0; xv[0 +: W] = -16'sd5;
        vec("neg1", xv, 1'b1, 15);
        vec("neg0", xv, 1'b0, -15);
        vec("zero_x", '0, 1'b0, 0);

        // Hold the result in DONE with out_ready low and try a coefficient write.
        send(xv, 1'b1, lat);
        check_eq("hold_lat", lat, W + 1);
        held = ysig();
        check_eq("hold_y0", held, 15);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("hold_y", ysig(), 15);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'd100;
        @(posedge clk); #1;
        coef_we = 1'b0;
        check_eq("coef_err_pulse", coef_err, 1);
        @(posedge clk); #1;
        check_eq("coef_err_clear", coef_err, 0);
        check_eq("hold_y_after_we", ysig(), 15);
        consume();
        check_eq("consume_valid", out_valid, 0);
        check_eq("consume_in_ready", in_ready, 1);
        vec("coef_kept", xv, 1'b1, 15);

        // Abort mid-RUN at bit 7 with an asynchronous reset.
        @(negedge clk);
        x_in = fill(16'd1); neg = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("run_in_ready", in_ready, 0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_y", ysig(), 0);
        check_eq("abort_coef_err", coef_err, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vec("after_abort", fill(16'd1), 1'b0, 0);

        load_coef(5, 2);
        xv = '0; xv[5*W +: W] = 16'd9;
        vec("reload", xv, 1'b0, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
